// File: rtl/timebase_pkg.sv
// Shared constants and helpers for the game-board timebase.
package timebase_pkg;

  // Blink channel modes, two bits per channel on ch_mode.
  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_ON   = 2'b01;
  localparam logic [1:0] MODE_SLOW = 2'b10;
  localparam logic [1:0] MODE_FAST = 2'b11;

  // Width of a counter that spans 0..n-1; never narrower than one bit.
  // Used for the phase counter, the scan prescaler and the digit index.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timebase_gen_if.sv
// Signal bundle around the timebase: run controls, blink modes, the
// random-sample request/response pair and all timing outputs.
//
// Random-sample handshake: rand_req is a one-cycle request sampled on a
// clock edge; the value captured at that edge appears on rand_out with
// rand_valid high for exactly one cycle on the following cycle. There is
// no backpressure: a request every cycle yields a sample every cycle.
interface timebase_gen_if
  import timebase_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int NUM_CH      = 2,
  parameter int SCAN_DIGITS = 8,
  parameter int LFSR_W      = 16
);
  localparam int PHASE_W = cnt_width(CLK_HZ);
  localparam int SCAN_W  = cnt_width(SCAN_DIGITS);

  logic                  en;
  logic                  sync_clr;
  logic [2*NUM_CH-1:0]   ch_mode;
  logic                  rand_req;
  logic [PHASE_W-1:0]    phase;
  logic                  sec_tick;
  logic                  half_tick;
  logic [NUM_CH-1:0]     blink_out;
  logic [SCAN_W-1:0]     scan_idx;
  logic                  scan_tick;
  logic [LFSR_W-1:0]     rand_out;
  logic                  rand_valid;

  // Controller side: drives run controls and requests, observes timing.
  modport master (
    output en, sync_clr, ch_mode, rand_req,
    input  phase, sec_tick, half_tick, blink_out, scan_idx, scan_tick,
           rand_out, rand_valid
  );

  // Timebase side.
  modport slave (
    input  en, sync_clr, ch_mode, rand_req,
    output phase, sec_tick, half_tick, blink_out, scan_idx, scan_tick,
           rand_out, rand_valid
  );
endinterface

// File: rtl/timebase_gen_lfsr.sv
// Free-running Galois LFSR, right-shifting every clock.
// A nonzero seed keeps the state out of the all-zero lock-up value.
module lfsr_gen #(
  parameter int           W    = 16,
  parameter logic [W-1:0] TAPS = 16'hB400,
  parameter logic [W-1:0] SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] state
);
  logic [W-1:0] state_q;
  logic [W-1:0] state_d;

  // Shift right; when the bit falling out is 1, fold the tap mask in.
  always_comb begin
    state_d = {1'b0, state_q[W-1:1]};
    if (state_q[0]) begin
      state_d = state_d ^ TAPS;
    end
  end

  // State register, reloads the seed on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;
endmodule

// File: rtl/timebase_gen.sv
// System timebase: 1 s phase counter with second/half-second ticks,
// per-channel blink generators, 7-segment digit scan, and on-demand
// samples of a free-running LFSR.
module timebase_gen
  import timebase_pkg::*;
#(
  parameter int                CLK_HZ      = 100_000_000,
  parameter int                NUM_CH      = 2,
  parameter int                SCAN_PERIOD = 4096,
  parameter int                SCAN_DIGITS = 8,
  parameter int                LFSR_W      = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS   = 16'hB400,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                sync_clr,
  input  logic [2*NUM_CH-1:0]                 ch_mode,
  input  logic                                rand_req,
  output logic [cnt_width(CLK_HZ)-1:0]        phase,
  output logic                                sec_tick,
  output logic                                half_tick,
  output logic [NUM_CH-1:0]                   blink_out,
  output logic [cnt_width(SCAN_DIGITS)-1:0]   scan_idx,
  output logic                                scan_tick,
  output logic [LFSR_W-1:0]                   rand_out,
  output logic                                rand_valid
);
  localparam int PHASE_W = cnt_width(CLK_HZ);
  localparam int PRESC_W = cnt_width(SCAN_PERIOD);
  localparam int SCAN_W  = cnt_width(SCAN_DIGITS);

  localparam logic [PHASE_W-1:0] PH_LAST      = PHASE_W'(CLK_HZ - 1);
  localparam logic [PHASE_W-1:0] PH_HALF_LAST = PHASE_W'(CLK_HZ / 2 - 1);
  localparam logic [PHASE_W-1:0] PH_Q1        = PHASE_W'(CLK_HZ / 4);
  localparam logic [PHASE_W-1:0] PH_Q2        = PHASE_W'(CLK_HZ / 2);
  localparam logic [PHASE_W-1:0] PH_Q3        = PHASE_W'(3 * (CLK_HZ / 4));
  localparam logic [PRESC_W-1:0] PRESC_LAST   = PRESC_W'(SCAN_PERIOD - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST    = SCAN_W'(SCAN_DIGITS - 1);

  // Quarter-phase blink needs CLK_HZ split into four equal parts, and a
  // zero seed would lock the LFSR at zero forever.
  if ((CLK_HZ % 4) != 0 || CLK_HZ < 4) begin : g_bad_clk_hz
    $error("timebase_gen: CLK_HZ must be a multiple of 4 and >= 4");
  end
  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("timebase_gen: LFSR_SEED must be nonzero");
  end

  // Blink level for one channel at a given phase.
  function automatic logic blink_level(input logic [1:0]         mode,
                                       input logic [PHASE_W-1:0] ph);
    logic lvl;
    lvl = 1'b0;
    case (mode)
      MODE_ON:   lvl = 1'b1;
      MODE_SLOW: lvl = (ph >= PH_Q2);
      MODE_FAST: lvl = ((ph >= PH_Q1) && (ph < PH_Q2)) || (ph >= PH_Q3);
      default:   lvl = 1'b0;
    endcase
    return lvl;
  endfunction

  // ---------------------------------------------------------------- phase
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               sec_tick_q, sec_tick_d;
  logic               half_tick_q, half_tick_d;

  // Phase advance with wrap; ticks flag the last cycle of each half.
  // sync_clr wins over en and suppresses the ticks for that cycle.
  always_comb begin
    phase_d     = phase_q;
    sec_tick_d  = 1'b0;
    half_tick_d = 1'b0;
    if (sync_clr) begin
      phase_d = '0;
    end else if (en) begin
      phase_d     = (phase_q == PH_LAST) ? '0 : phase_q + PHASE_W'(1);
      sec_tick_d  = (phase_q == PH_LAST);
      half_tick_d = (phase_q == PH_LAST) || (phase_q == PH_HALF_LAST);
    end
  end

  // Phase and tick registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= '0;
      sec_tick_q  <= 1'b0;
      half_tick_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      sec_tick_q  <= sec_tick_d;
      half_tick_q <= half_tick_d;
    end
  end

  // ---------------------------------------------------------------- blink
  logic [NUM_CH-1:0]  blink_q, blink_d;
  logic [PHASE_W-1:0] blink_phase;

  // Each channel follows the current phase one cycle later; a restart
  // evaluates from phase 0 so the outputs line up with the new phase.
  always_comb begin
    blink_phase = sync_clr ? '0 : phase_q;
    blink_d     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      blink_d[k] = blink_level(ch_mode[2*k +: 2], blink_phase);
    end
  end

  // Blink output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_d;
    end
  end

  // ----------------------------------------------------------------- scan
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [SCAN_W-1:0]  scan_idx_q, scan_idx_d;
  logic               scan_tick_q, scan_tick_d;
  logic               presc_wrap;

  // Prescaler wrap steps the digit index; the explicit last-digit compare
  // lets digit counts that are not powers of two wrap correctly.
  always_comb begin
    presc_wrap  = (presc_q == PRESC_LAST);
    presc_d     = presc_q;
    scan_idx_d  = scan_idx_q;
    scan_tick_d = 1'b0;
    if (sync_clr) begin
      presc_d    = '0;
      scan_idx_d = '0;
    end else if (en) begin
      presc_d     = presc_wrap ? '0 : presc_q + PRESC_W'(1);
      scan_tick_d = presc_wrap;
      if (presc_wrap) begin
        scan_idx_d = (scan_idx_q == SCAN_LAST) ? '0 : scan_idx_q + SCAN_W'(1);
      end
    end
  end

  // Scan prescaler, digit index and strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q     <= '0;
      scan_idx_q  <= '0;
      scan_tick_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      scan_idx_q  <= scan_idx_d;
      scan_tick_q <= scan_tick_d;
    end
  end

  // --------------------------------------------------------------- random
  logic [LFSR_W-1:0] lfsr_state;
  logic [LFSR_W-1:0] rand_out_q, rand_out_d;
  logic              rand_valid_q, rand_valid_d;

  lfsr_gen #(
    .W    (LFSR_W),
    .TAPS (LFSR_TAPS),
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr_state)
  );

  // Capture the LFSR state present at the requesting edge; hold otherwise.
  always_comb begin
    rand_out_d   = rand_req ? lfsr_state : rand_out_q;
    rand_valid_d = rand_req;
  end

  // Sample and valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rand_out_q   <= '0;
      rand_valid_q <= 1'b0;
    end else begin
      rand_out_q   <= rand_out_d;
      rand_valid_q <= rand_valid_d;
    end
  end

  assign phase      = phase_q;
  assign sec_tick   = sec_tick_q;
  assign half_tick  = half_tick_q;
  assign blink_out  = blink_q;
  assign scan_idx   = scan_idx_q;
  assign scan_tick  = scan_tick_q;
  assign rand_out   = rand_out_q;
  assign rand_valid = rand_valid_q;
endmodule

// File: doc/timebase_gen.md
Name: timebase_gen

Overview:
- Parametrised system timebase for the game board.
- Produces a 1 s phase counter, one-cycle second/half-second ticks, NUM_CH independently moded blink outputs, a display-scan digit index with strobe, and an on-demand pseudo-random sample from a free-running LFSR.
- Sits beside the game FSM. Feeds the LED, 7-segment scan and card-shuffle logic.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency; phase period in cycles. Must be divisible by 4 and >= 4.
- NUM_CH, 2, number of blink channels.
- SCAN_PERIOD, 4096, clk cycles per scan digit; >= 1.
- SCAN_DIGITS, 8, digits scanned; scan_idx wraps at SCAN_DIGITS-1; >= 2.
- LFSR_W, 16, LFSR width.
- LFSR_TAPS, 16'hB400, Galois feedback mask.
- LFSR_SEED, 16'hACE1, reset state; must be nonzero.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  timebase run enable
- sync_clr  in  1  synchronous phase restart
- ch_mode  in  2*NUM_CH  per-channel mode; channel k uses bits [2k+1:2k]
- rand_req  in  1  random sample request
- phase  out  $clog2(CLK_HZ)  current phase, 0..CLK_HZ-1
- sec_tick  out  1  one-cycle pulse per phase wrap
- half_tick  out  1  one-cycle pulse at phase CLK_HZ/2-1 and CLK_HZ-1
- blink_out  out  NUM_CH  blink outputs
- scan_idx  out  $clog2(SCAN_DIGITS)  active display digit
- scan_tick  out  1  one-cycle pulse on scan_idx advance
- rand_out  out  LFSR_W  sampled random value
- rand_valid  out  1  one-cycle pulse, rand_out updated

Behaviour:
- Reset (async, rst=1) sets:
  - phase=0, sec_tick=0, half_tick=0, blink_out=0;
  - scan prescaler=0, scan_idx=0, scan_tick=0;
  - lfsr=LFSR_SEED, rand_out=0, rand_valid=0.
- Phase counter:
  - When en=1, phase increments each cycle and wraps CLK_HZ-1 -> 0, giving a period of exactly CLK_HZ cycles.
  - When en=0, phase holds.
- sec_tick is registered. It is 1 in the cycle after phase==CLK_HZ-1 with en=1.
- half_tick is registered. It is 1 in the cycle after phase==CLK_HZ/2-1 or phase==CLK_HZ-1 with en=1.
- Blink modes, per channel, registered; output reflects the current phase one cycle later:
  - 00 OFF: 0.
  - 01 ON: 1.
  - 10 SLOW: 0 for phase < CLK_HZ/2, else 1.
  - 11 FAST: 0,1,0,1 over the four quarters of the phase.
  - A mode change appears on blink_out the next cycle. The phase is not reset by a mode change.
- Scan:
  - The prescaler counts 0..SCAN_PERIOD-1 while en=1.
  - On prescaler wrap, scan_idx advances, wrapping SCAN_DIGITS-1 -> 0 (supports non-power-of-2 digit counts), and scan_tick pulses in the same cycle as the scan_idx change.
  - When en=0, the prescaler and scan_idx hold.
- sync_clr has priority over en. Next cycle: phase=0, prescaler=0, scan_idx=0; ticks are 0 that cycle. Blink outputs are recomputed from phase 0. The LFSR is unaffected.
- LFSR:
  - Galois right-shift each cycle regardless of en or sync_clr.
  - With a nonzero seed the state is never 0.
- Random sample: rand_req=1 at edge N gives rand_out = LFSR state at edge N and rand_valid=1 at N+1. Back-to-back requests give a valid every cycle with differing values.
- Reset asserted mid-operation clears everything immediately, with no waiting for a clock edge. Release is synchronous to the next edge.

Decomposition:
- Package timebase_pkg holds:
  - mode constants MODE_OFF=2'b00, MODE_ON=2'b01, MODE_SLOW=2'b10, MODE_FAST=2'b11;
  - a function for the phase width.
- One sub-module, lfsr_gen (params W, TAPS, SEED; ports clk, rst, state), instantiated once.
- Elaboration-time check that CLK_HZ%4==0 and LFSR_SEED!=0.

Test Plan:
- Reset/count, with CLK_HZ=8, en=1 after rst release:
  - phase follows 0..7,0;
  - sec_tick high exactly in the cycle after phase=7;
  - half_tick high after phase=3 and after phase=7.
- Blink modes, CLK_HZ=8, ch_mode={FAST,SLOW}:
  - ch0 is 0,0,0,0,1,1,1,1 (lagging phase by 1 cycle);
  - ch1 is 0,0,1,1,0,0,1,1;
  - switching ch0 to ON gives blink_out[0]=1 the next cycle.
- en/sync_clr:
  - Drop en at phase=5 for 10 cycles: phase stays 5, no ticks.
  - Assert sync_clr together with en=0: phase=0 and scan_idx=0 next cycle.
- Scan wrap, SCAN_PERIOD=2, SCAN_DIGITS=6: scan_idx runs 0..5,0 with a change every 2 cycles, and scan_tick fires 6 times per 12 cycles.
- Random:
  - After reset, rand_req on the first edge gives rand_out=16'hACE1, rand_valid=1.
  - 3 back-to-back requests give 3 distinct nonzero values matching the Galois reference model.
  - Over 65535 cycles the LFSR never equals 0 and returns to seed only at cycle 65535.
- Async reset asserted mid-cycle at phase=6 with FAST blink: all outputs clear before the next clk edge, and counting restarts from 0 after release.
